// File: rtl/pp_pkg.sv
// Shared frame layout, state encoding and group-count helper for pp_decoder and pp_encoder.
// Supplies fallback values for the TOTAL_UART / TOTAL_GPIO_CTRLS build macros.
`ifndef TOTAL_UART
`define TOTAL_UART 8
`endif
`ifndef TOTAL_GPIO_CTRLS
`define TOTAL_GPIO_CTRLS 8
`endif

package pp_pkg;
  localparam logic [1:0] PP_TYPE_WRITE = 2'b00;
  localparam logic [1:0] PP_TYPE_READ  = 2'b01;
  localparam logic [1:0] PP_TYPE_CTRL  = 2'b10;
  localparam logic [1:0] PP_TYPE_RSVD  = 2'b11;

  localparam int PP_FRAME_W   = 48;
  localparam int PP_TYPE_HI   = 47;
  localparam int PP_TYPE_LO   = 46;
  localparam int PP_ID_HI     = 45;
  localparam int PP_ID_LO     = 40;
  localparam int PP_PAYLOAD_W = 40;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_WR, S_RD, S_CTRL, S_ERR
  } pp_dec_state_e;

  // Peripherals are addressed four to a group.
  function automatic int grp_count(input int n);
    return (n + 3) >> 2;
  endfunction
endpackage

// File: rtl/pp_dec_timer.sv
// Ack-timeout counter for pp_decoder; compiled only when PP_DEC_TIMEOUT_EN is defined.
`ifdef PP_DEC_TIMEOUT_EN
module pp_dec_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Fires on the TIMEOUT_CYCLES-th cycle spent running since the last clear.
  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (run && !expired)  cnt <= cnt + 1'b1;
  end
endmodule
`endif

// File: rtl/pp_decoder.sv
// Host command dispatcher: pops 48-bit frames, issues group writes or encoder reads, drops bad frames.
// Optional ack timeout is enabled by defining PP_DEC_TIMEOUT_EN.
module pp_decoder
  import pp_pkg::*;
#(
  parameter int TOTAL_UART        = `TOTAL_UART,
  parameter int TOTAL_GPIO_CTRLS  = `TOTAL_GPIO_CTRLS,
  parameter int UART_TOTAL_GRP    = grp_count(TOTAL_UART),
  parameter int GPIO_TOTAL_GRP    = grp_count(TOTAL_GPIO_CTRLS),
  parameter int TOTAL_GRP         = UART_TOTAL_GRP + GPIO_TOTAL_GRP,
  parameter int WR_DATA_BUS_WIDTH = 48,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  input  logic [WR_DATA_BUS_WIDTH-1:0] fifo_data,
  output logic                         fifo_rd_en,
  output logic [TOTAL_GRP-1:0]         wr_req,
  output logic [PP_PAYLOAD_W-1:0]      wr_data,
  input  logic [TOTAL_GRP-1:0]         wr_ack,
  output logic                         rd_req,
  output logic [TOTAL_GRP-1:0]         rd_slave_id,
  input  logic                         rd_req_ack,
  output logic                         busy,
  output logic                         err_pulse,
  output logic [7:0]                   err_cnt
);
  pp_dec_state_e                  state;
  logic [WR_DATA_BUS_WIDTH-1:0]   r_frame;
  logic [1:0]                     f_type;
  logic [PP_ID_HI-PP_ID_LO:0]     f_id;
  logic                           id_ok;
  logic                           wr_done;

  assign f_type  = r_frame[PP_TYPE_HI:PP_TYPE_LO];
  assign f_id    = r_frame[PP_ID_HI:PP_ID_LO];
  assign id_ok   = int'(f_id) < TOTAL_GRP;
  // wr_req is one-hot on the addressed group, so masking filters out other groups' acks.
  assign wr_done = |(wr_ack & wr_req);
  assign busy    = (state != S_IDLE);

`ifdef PP_DEC_TIMEOUT_EN
  logic expired;

  pp_dec_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == S_DECODE),
    .run     (state == S_WR || state == S_RD),
    .expired (expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      r_frame     <= '0;
      fifo_rd_en  <= 1'b0;
      wr_req      <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_slave_id <= '0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        S_IDLE: if (!fifo_empty) begin
          fifo_rd_en <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: state <= S_LATCH;
        // FIFO read data lands two cycles after the pop.
        S_LATCH: begin
          r_frame <= fifo_data;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (f_type == PP_TYPE_RSVD || (f_type != PP_TYPE_CTRL && !id_ok)) begin
            state <= S_ERR;
          end else if (f_type == PP_TYPE_WRITE) begin
            wr_req  <= TOTAL_GRP'(1) << f_id;
            wr_data <= r_frame[PP_PAYLOAD_W-1:0];
            state   <= S_WR;
          end else if (f_type == PP_TYPE_READ) begin
            rd_req      <= 1'b1;
            rd_slave_id <= TOTAL_GRP'(f_id);
            state       <= S_RD;
          end else begin
            state <= S_CTRL;
          end
        end
        S_WR: begin
          if (wr_done) begin
            wr_req <= '0;
            state  <= S_IDLE;
          end
`ifdef PP_DEC_TIMEOUT_EN
          else if (expired) begin
            wr_req <= '0;
            state  <= S_ERR;
          end
`endif
        end
        S_RD: begin
          if (rd_req_ack) begin
            rd_req <= 1'b0;
            state  <= S_IDLE;
          end
`ifdef PP_DEC_TIMEOUT_EN
          else if (expired) begin
            rd_req <= 1'b0;
            state  <= S_ERR;
          end
`endif
        end
        S_CTRL: begin
          if (r_frame[0]) err_cnt <= '0;
          state <= S_IDLE;
        end
        S_ERR: begin
          err_pulse <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
